wb_restoring_divider: RTL
=========================

WB_RESTORING_DIVIDER -- requirements
Module: wb_restoring_divider

Interface
REQ-001 SHALL have parameter P_DIV_WIDTH, default 32, operand and result width in bits.
REQ-002 SHALL have port Clock  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_wb4s_cyc  input  1  bus cycle active; low aborts any operation.
REQ-005 SHALL have port i_wb4s_stb  input  1  request strobe, valid with cyc.
REQ-006 SHALL have port i_wb4s_tgc  input  2  bit1: 0=quotient, 1=remainder; bit0: 0=signed, 1=unsigned.
REQ-007 SHALL have port i_wb4s_data  input  2*P_DIV_WIDTH  {divisor, dividend}, dividend in low half.
REQ-008 SHALL have port o_wb4s_stall  output  1  high while a request cannot be accepted.
REQ-009 SHALL have port o_wb4s_ack  output  1  one-cycle pulse, result valid on o_wb4s_data.
REQ-010 SHALL have port o_wb4s_data  output  P_DIV_WIDTH  selected result.

Function
REQ-011 SHALL accept a request on a rising edge where cyc=1, stb=1, stall=0; it latches data, tgc, and operand signs.
REQ-012 SHALL implement states IDLE, ITER, FIX, ACK; IDLE->ITER on accept; ITER->FIX after P_DIV_WIDTH iterations; FIX->ACK; ACK->IDLE.
REQ-013 SHALL hold stall=0 only in IDLE; stall=1 in ITER, FIX, ACK.
REQ-014 SHALL in signed mode convert both operands to magnitudes at accept.
REQ-015 SHALL in ITER perform one restoring step per cycle: shift {rem,quot} left, trial-subtract divisor, keep the result if non-negative, set quotient bit accordingly.
REQ-016 SHALL in FIX apply signs: quotient negated if operand signs differ; remainder takes the dividend sign.
REQ-017 SHALL assert ack for exactly one cycle in ACK with o_wb4s_data=quotient or remainder per tgc bit1; latency accept-edge to ack = P_DIV_WIDTH+2 cycles (34 for 32).
REQ-018 SHALL hold o_wb4s_data at the last result until the next ack.
REQ-019 SHALL for divisor 0 return quotient all-ones and remainder = dividend, both modes.
REQ-020 SHALL for signed most-negative / -1 return quotient = most-negative value and remainder 0.
REQ-021 SHALL abort on cyc=0 in ITER or FIX: go to IDLE next edge, no ack, o_wb4s_data unchanged.
REQ-022 SHALL ignore stb while stall=1; a request held across ACK is accepted on the first IDLE edge.
REQ-023 SHALL not accept a request while cyc=0 regardless of stb.

Reset
REQ-024 SHALL on Reset=1 immediately force state IDLE, stall=0, ack=0, o_wb4s_data=0, internal registers 0.
REQ-025 SHALL discard an operation in progress on reset with no ack after release.
REQ-026 SHALL accept a request on the first rising edge after Reset deasserts.

Configuration
REQ-027 SHALL with macro DIV_ZERO_SHORTCUT_EN defined detect divisor 0 at accept and skip ITER (IDLE->FIX->ACK), ack 2 cycles after accept with REQ-019 results.
REQ-028 SHALL without DIV_ZERO_SHORTCUT_EN handle divisor 0 through the full ITER sequence, latency per REQ-017, same results.

Verification
REQ-029 SHALL cover unsigned 100/7, tgc=2'b01 -> ack after 34 cycles, data=14; tgc=2'b11 -> data=2.
REQ-030 SHALL cover signed -100/7, tgc=2'b00 -> 0xFFFFFFF2 (-14); tgc=2'b10 -> 0xFFFFFFFE (-2).
REQ-031 SHALL cover 0x80000000/0xFFFFFFFF signed -> quotient 0x80000000, remainder 0.
REQ-032 SHALL cover 55/0 -> quotient 0xFFFFFFFF, remainder 55; ack at cycle 2 with macro, 34 without.
REQ-033 SHALL cover cyc dropped at iteration 10 -> no ack, stall=0 next cycle; new 9/3 request -> 3.
REQ-034 SHALL cover Reset pulse mid-ITER -> ack=0, data=0, stall=0 immediately; no later ack.

Source files
------------

// File: rtl/wb_restoring_divider.sv
// Wishbone-style restoring divider: one quotient bit per cycle, signed/unsigned, quotient or remainder.
// Optional macro DIV_ZERO_SHORTCUT_EN: a zero divisor skips the iteration phase.
module wb_restoring_divider #(
  parameter int unsigned P_DIV_WIDTH = 32
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       i_wb4s_cyc,
  input  logic                       i_wb4s_stb,
  input  logic [1:0]                 i_wb4s_tgc,
  input  logic [2*P_DIV_WIDTH-1:0]   i_wb4s_data,
  output logic                       o_wb4s_stall,
  output logic                       o_wb4s_ack,
  output logic [P_DIV_WIDTH-1:0]     o_wb4s_data
);

  localparam int unsigned W     = P_DIV_WIDTH;
  localparam int unsigned CNT_W = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_ACK  = 2'd3;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [W-1:0]     rem;
  logic [W-1:0]     quot;
  logic [W-1:0]     dvsr;
  logic [CNT_W-1:0] cnt;
  logic             rem_sel;
  logic             sign_dd;
  logic             sign_dv;

  logic [W-1:0] dividend_in;
  logic [W-1:0] divisor_in;
  logic         is_signed;
  logic         accept;
  logic [W:0]   rem_sh;
  logic         trial_ok;
  logic [W-1:0] trial_diff;
  logic [W-1:0] quot_fix;
  logic [W-1:0] rem_fix;

  function automatic logic [W-1:0] mag(input logic [W-1:0] x, input logic neg);
    return neg ? (W'(0) - x) : x;
  endfunction

  assign dividend_in  = i_wb4s_data[W-1:0];
  assign divisor_in   = i_wb4s_data[2*W-1:W];
  assign is_signed    = ~i_wb4s_tgc[0];
  assign accept       = (state == S_IDLE) && i_wb4s_cyc && i_wb4s_stb;
  assign o_wb4s_stall = (state != S_IDLE);

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  // When the subtraction succeeds the result is below dvsr, so W-bit modular arithmetic is exact.
  assign rem_sh     = {rem, quot[W-1]};
  assign trial_ok   = (rem_sh >= {1'b0, dvsr});
  assign trial_diff = rem_sh[W-1:0] - dvsr;

  // Sign fix-up; a zero divisor always yields an all-ones quotient regardless of mode.
  assign quot_fix = (dvsr == '0) ? '1 : mag(quot, sign_dd ^ sign_dv);
  assign rem_fix  = mag(rem, sign_dd);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
`ifdef DIV_ZERO_SHORTCUT_EN
          next_state = (divisor_in == '0) ? S_FIX : S_ITER;
`else
          next_state = S_ITER;
`endif
        end
      end
      S_ITER: begin
        if (!i_wb4s_cyc)                      next_state = S_IDLE;
        else if (cnt == CNT_W'(W - 1))        next_state = S_FIX;
      end
      S_FIX:   next_state = i_wb4s_cyc ? S_ACK : S_IDLE;
      S_ACK:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rem          <= '0;
      quot         <= '0;
      dvsr         <= '0;
      cnt          <= '0;
      rem_sel      <= 1'b0;
      sign_dd      <= 1'b0;
      sign_dv      <= 1'b0;
      o_wb4s_ack   <= 1'b0;
      o_wb4s_data  <= '0;
    end else begin
      o_wb4s_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            rem_sel <= i_wb4s_tgc[1];
            sign_dd <= is_signed & dividend_in[W-1];
            sign_dv <= is_signed & divisor_in[W-1];
            dvsr    <= mag(divisor_in, is_signed & divisor_in[W-1]);
            cnt     <= '0;
`ifdef DIV_ZERO_SHORTCUT_EN
            if (divisor_in == '0) begin
              // Division by zero leaves the dividend magnitude as the remainder.
              rem  <= mag(dividend_in, is_signed & dividend_in[W-1]);
              quot <= '0;
            end else begin
              rem  <= '0;
              quot <= mag(dividend_in, is_signed & dividend_in[W-1]);
            end
`else
            rem  <= '0;
            quot <= mag(dividend_in, is_signed & dividend_in[W-1]);
`endif
          end
        end
        S_ITER: begin
          rem  <= trial_ok ? trial_diff : rem_sh[W-1:0];
          quot <= {quot[W-2:0], trial_ok};
          cnt  <= cnt + CNT_W'(1);
        end
        S_FIX: begin
          quot <= quot_fix;
          rem  <= rem_fix;
        end
        S_ACK: begin
          o_wb4s_ack  <= 1'b1;
          o_wb4s_data <= rem_sel ? rem : quot;
        end
        default: ;
      endcase
    end
  end

endmodule
